// File: rtl/tdm_demux4.sv
// tdm_demux4: four-channel time-division demultiplexer.
// Hunts for SYNC, stages slots 0..2, and loads all four outputs at slot 3.
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         EN,
    input  logic         SYNC,
    input  logic [W-1:0] D,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [1:0]   SEL,
    output logic         LOCKED,
    output logic         FRAME_VALID,
    output logic         SYNC_ERR
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   sel_q, sel_d;
    logic [W-1:0] s0_q, s0_d;
    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] y0_q, y0_d;
    logic [W-1:0] y1_q, y1_d;
    logic [W-1:0] y2_q, y2_d;
    logic [W-1:0] y3_q, y3_d;
    logic         fv_q, fv_d;
    logic         err_q, err_d;

    // Register all state; reset discards any partial frame and clears outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= HUNT;
            sel_q   <= 2'd0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    // Next-state: slot tracking, staging, frame commit and error pulses.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        if (EN) begin
            unique case (state_q)
                HUNT: begin
                    if (SYNC) begin
                        s0_d    = D;
                        sel_d   = 2'd1;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (SYNC) begin
                        // Early sync drops the partial frame and restarts at slot 0.
                        err_d = (sel_q != 2'd0);
                        s0_d  = D;
                        sel_d = 2'd1;
                    end else begin
                        unique case (sel_q)
                            2'd0: begin
                                err_d   = 1'b1;
                                state_d = HUNT;
                            end
                            2'd1: begin
                                s1_d  = D;
                                sel_d = 2'd2;
                            end
                            2'd2: begin
                                s2_d  = D;
                                sel_d = 2'd3;
                            end
                            2'd3: begin
                                y0_d  = s0_q;
                                y1_d  = s1_q;
                                y2_d  = s2_q;
                                y3_d  = D;
                                fv_d  = 1'b1;
                                sel_d = 2'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign Y0          = y0_q;
    assign Y1          = y1_q;
    assign Y2          = y2_q;
    assign Y3          = y3_q;
    assign SEL         = sel_q;
    assign LOCKED      = (state_q == LOCK);
    assign FRAME_VALID = fv_q;
    assign SYNC_ERR    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4.
// Frame-level model predicts per-cycle state and committed frames.
module tb_tdm_demux4;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         EN = 1'b0;
    logic         SYNC = 1'b0;
    logic [W-1:0] D = '0;
    logic [W-1:0] Y0, Y1, Y2, Y3;
    logic [1:0]   SEL;
    logic         LOCKED, FRAME_VALID, SYNC_ERR;

    tdm_demux4 #(.W(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .SYNC(SYNC), .D(D),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
        .SEL(SEL), .LOCKED(LOCKED),
        .FRAME_VALID(FRAME_VALID), .SYNC_ERR(SYNC_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             fv;
        logic             err;
        logic             locked;
        logic [1:0]       sel;
        logic [3:0][W-1:0] y;
    } exp_t;

    exp_t              cyc_q[$];
    logic [3:0][W-1:0] frm_q[$];

    int passed = 0;
    int total  = 0;

    // Reference model state: frame words collected so far while locked.
    logic [W-1:0]      frame_w[$];
    logic              m_locked = 1'b0;
    logic [3:0][W-1:0] m_y = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(logic rst_n, logic en, logic sync, logic [W-1:0] d);
        exp_t e;
        @(negedge CLK);
        RST_N = rst_n;
        EN    = en;
        SYNC  = sync;
        D     = d;
        e.fv  = 1'b0;
        e.err = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0;
            frame_w.delete();
            m_y = '0;
        end else if (en) begin
            if (!m_locked) begin
                if (sync) begin
                    frame_w.delete();
                    frame_w.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (sync) begin
                e.err = (frame_w.size() != 0);
                frame_w.delete();
                frame_w.push_back(d);
            end else if (frame_w.size() == 0) begin
                e.err = 1'b1;
                m_locked = 1'b0;
            end else begin
                frame_w.push_back(d);
                if (frame_w.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = frame_w[i];
                    e.fv = 1'b1;
                    frm_q.push_back(m_y);
                    frame_w.delete();
                end
            end
        end
        e.locked = m_locked;
        e.sel    = 2'(frame_w.size());
        e.y      = m_y;
        cyc_q.push_back(e);
    endtask

    task automatic word(logic sync, logic [W-1:0] d);
        cycle(1'b1, 1'b1, sync, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, W'(4'hF));
    endtask

    // Monitor: after each edge, check cycle state and pop a frame on FRAME_VALID.
    always @(posedge CLK) begin
        #1;
        if (cyc_q.size() != 0) begin
            exp_t e;
            e = cyc_q.pop_front();
            chk("frame_valid", 32'(FRAME_VALID), 32'(e.fv));
            chk("sync_err", 32'(SYNC_ERR), 32'(e.err));
            chk("locked", 32'(LOCKED), 32'(e.locked));
            chk("sel", 32'(SEL), 32'(e.sel));
            chk("y_hold", 32'({Y3, Y2, Y1, Y0}), 32'(e.y));
        end
        if (FRAME_VALID === 1'b1) begin
            if (frm_q.size() == 0) begin
                chk("unexpected_frame", 32'(1), 32'(0));
            end else begin
                logic [3:0][W-1:0] f;
                f = frm_q.pop_front();
                chk("frame_y", 32'({Y3, Y2, Y1, Y0}), 32'(f));
            end
        end
    end

    initial begin
        // Reset then clean frame
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b1, W'(4'h7));
        word(1'b1, W'(4'hA));
        word(1'b0, W'(4'hB));
        word(1'b0, W'(4'hC));
        word(1'b0, W'(4'hD));
        idle(2);
        // Gapped frame
        word(1'b1, W'(4'h1));
        idle(2);
        word(1'b0, W'(4'h2));
        idle(1);
        word(1'b0, W'(4'h3));
        idle(3);
        word(1'b0, W'(4'h4));
        idle(1);
        // HUNT discard
        cycle(1'b0, 1'b0, 1'b0, '0);
        word(1'b0, W'(4'h9));
        word(1'b0, W'(4'h9));
        word(1'b0, W'(4'h9));
        word(1'b1, W'(4'h1));
        word(1'b0, W'(4'h2));
        word(1'b0, W'(4'h3));
        word(1'b0, W'(4'h4));
        idle(1);
        // Early sync, including sync on slot 3
        word(1'b1, W'(4'h1));
        word(1'b0, W'(4'h2));
        word(1'b1, W'(4'h5));
        word(1'b0, W'(4'h6));
        word(1'b0, W'(4'h7));
        word(1'b0, W'(4'h8));
        word(1'b1, W'(4'hE));
        word(1'b0, W'(4'hE));
        word(1'b0, W'(4'hE));
        word(1'b1, W'(4'h0));
        idle(1);
        // Missing sync after a good frame
        word(1'b0, W'(4'h1));
        word(1'b0, W'(4'h2));
        word(1'b0, W'(4'h3));
        word(1'b0, W'(4'h4));
        word(1'b0, W'(4'h5));
        word(1'b0, W'(4'h6));
        word(1'b0, W'(4'h7));
        // Mid-frame reset
        word(1'b1, W'(4'hC));
        word(1'b0, W'(4'hD));
        cycle(1'b0, 1'b1, 1'b0, W'(4'hE));
        word(1'b1, W'(4'h3));
        word(1'b0, W'(4'h5));
        word(1'b0, W'(4'h7));
        word(1'b0, W'(4'h9));
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, en, sy;
            r  = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 3) != 0);
            sy = ($urandom_range(0, 5) == 0);
            cycle(r, en, sy, W'($urandom));
        end
        idle(3);
        @(negedge CLK);
        chk("cycle_queue_drained", 32'(cyc_q.size()), 32'(0));
        chk("frame_queue_drained", 32'(frm_q.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer, the receive end of a 4:1 select-line multiplexer link. A serial word stream carries channel slots 0..3 in order, and a SYNC flag marks slot 0. The block tracks slot position with a 2-bit counter and captures each slot into a staging register. At the end of each complete frame it updates all four channel outputs together. It sits downstream of the 4:1 mux path and restores the four parallel channels.

## Interface
Parameters:
- W, 1, width of each channel word and of the serial data input.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
- EN  input  1  slot strobe; D and SYNC are valid and consumed only when EN=1.
- SYNC  input  1  high with EN on the slot-0 word of each frame.
- D  input  W  serial slot data.
- Y0, Y1, Y2, Y3  output  W each  registered channel outputs, updated atomically once per frame.
- SEL  output  2  slot index expected on the next EN; equivalent to {S1,S0} on the sending mux.
- LOCKED  output  1  high while the block is in state LOCK.
- FRAME_VALID  output  1  one-cycle pulse when Y0..Y3 have just been loaded.
- SYNC_ERR  output  1  one-cycle pulse on a framing violation.

## Operation
- States: HUNT and LOCK. Internal state: staging registers S0..S2 (W bits each) and the slot counter, which drives SEL.
- Reset (RST_N=0 at an edge) puts the block in HUNT with SEL=0 and S0..S2=0. Y0..Y3, LOCKED, FRAME_VALID and SYNC_ERR all go to 0. Reset has priority over every other input, including mid-frame; a partial frame is discarded and Y0..Y3 are cleared.
- EN=0: nothing changes, except that FRAME_VALID and SYNC_ERR return to 0.
- HUNT:
  - EN=1, SYNC=0: word is discarded; no error is flagged.
  - EN=1, SYNC=1: S0←D, SEL←1, state→LOCK.
- LOCK, EN=1, SYNC=0:
  - SEL=1 or 2: S[SEL]←D, SEL←SEL+1.
  - SEL=3: Y0←S0, Y1←S1, Y2←S2, Y3←D, FRAME_VALID←1, SEL←0 (wrap-around).
  - SEL=0 (missing sync): SYNC_ERR←1, state→HUNT, word is discarded, SEL stays 0.
- LOCK, EN=1, SYNC=1:
  - SEL=0: S0←D, SEL←1. This is the normal frame start.
  - SEL≠0 (early sync): SYNC_ERR←1 and the partial frame is dropped. The word is treated as a new slot 0: S0←D, SEL←1, state stays LOCK.
- SYNC=1 together with SEL=3 counts as an early sync. That frame's Y update does not happen, and FRAME_VALID stays 0.
- Y0..Y3 hold their values between frames and never show partial frames.
- No arithmetic beyond the SEL increment, which is modulo 4.

## Timing
- All outputs are registered and change only on rising CLK edges.
- Latency: slot-3 word accepted at edge k → Y0..Y3 valid and FRAME_VALID=1 from edge k. FRAME_VALID returns to 0 at edge k+1 unless another frame completes at k+1. Back-to-back frames are not possible, because a frame needs at least 4 EN cycles.
- Minimum frame length is 4 consecutive EN cycles. EN gaps within a frame are allowed and have no timeout.
- SYNC_ERR is high for exactly the cycle after the offending edge.
- LOCKED follows state with the same registered timing.
- SEL after edge k shows the slot the next EN word will fill.

## Test plan
- Reset then clean frame (W=4): after reset, check all outputs are 0. Apply EN=1 for 4 cycles with SYNC=1 on the first, D=A,B,C,D. Required: FRAME_VALID pulse after the 4th edge; Y0..Y3=A,B,C,D; SEL=0; LOCKED=1.
- Gapped frame: same data with EN=0 cycles between slots. Required: same result; Y unchanged and FRAME_VALID=0 until the 4th EN.
- HUNT discard: 3 EN words with SYNC=0 (9,9,9), then a sync frame 1,2,3,4. Required: the 9s are ignored; Y=1,2,3,4; SYNC_ERR never asserted.
- Early sync: sync frame starting 1,2 then SYNC=1 with 5, followed by 6,7,8. Required: SYNC_ERR pulse on the 3rd word; the next FRAME_VALID gives Y=5,6,7,8; the previous Y values are held in between.
- Missing sync: after a good frame, 4 words with SYNC=0. Required: SYNC_ERR on the 1st word; LOCKED→0; Y unchanged; no FRAME_VALID.
- Mid-frame reset: RST_N=0 for one edge after 2 slots of a frame, then a full sync frame. Required: outputs are 0 after the reset edge, and the new frame alone produces Y.
